// File: rtl/synaptic_processing_unit3_pkg.sv
// Shared definitions for the synaptic processing unit: FSM state encoding
// and the saturation limits used by the accumulate datapath.
package spu_pkg;

    // One-hot state encoding, one bit per FSM state.
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_DEQ   = 6'b000010,
        S_LATCH = 6'b000100,
        S_READ  = 6'b001000,
        S_ACC   = 6'b010000,
        S_WRITE = 6'b100000
    } state_t;

    // Largest value representable in a (width+1)-bit two's complement word.
    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

    // Most negative value representable in a (width+1)-bit two's complement word.
    function automatic int sat_min(input int width);
        return -(1 << width);
    endfunction

endpackage

// File: rtl/synaptic_processing_unit3_if.sv
// Bus between the synaptic processing unit and its spike FIFO and the
// weight / i_next memories. The unit is the master; the FIFO and memories
// sit on the slave side.
interface synaptic_processing_unit3_if #(
    parameter int numwidth = 16,
    parameter int tagbits  = 1
);
    logic                     fifo_empty;
    logic [tagbits-1:0]       src_tag_in;
    logic signed [numwidth:0] weight_in;
    logic signed [numwidth:0] i_next_in;
    logic                     req_deq;
    logic                     req_read;
    logic                     req_write_i_next;
    logic signed [numwidth:0] i_next_out;
    logic [tagbits-1:0]       src_tag_out;
    logic [tagbits-1:0]       dst_tag_out;
    logic                     busy;
    logic                     spike_done;

    modport master (
        input  fifo_empty, src_tag_in, weight_in, i_next_in,
        output req_deq, req_read, req_write_i_next, i_next_out,
               src_tag_out, dst_tag_out, busy, spike_done
    );

    modport slave (
        output fifo_empty, src_tag_in, weight_in, i_next_in,
        input  req_deq, req_read, req_write_i_next, i_next_out,
               src_tag_out, dst_tag_out, busy, spike_done
    );
endinterface

// File: rtl/synaptic_processing_unit3_sat_adder.sv
// Combinational saturating adder for (numwidth+1)-bit two's complement
// operands. The sum is formed one bit wider so overflow shows up as a
// disagreement between the two top bits, and is then clamped.
module sat_adder
    import spu_pkg::*;
#(
    parameter int numwidth = 16
) (
    input  logic signed [numwidth:0] a,
    input  logic signed [numwidth:0] b,
    output logic signed [numwidth:0] sum
);
    localparam int max_i = sat_max(numwidth);
    localparam int min_i = sat_min(numwidth);
    localparam logic signed [numwidth:0] max_v = max_i[numwidth:0];
    localparam logic signed [numwidth:0] min_v = min_i[numwidth:0];

    logic signed [numwidth+1:0] wide;

    // Widen, add, then clamp toward the limit on the side that overflowed.
    always_comb begin
        wide = {a[numwidth], a} + {b[numwidth], b};
        if (wide[numwidth+1] != wide[numwidth]) begin
            sum = wide[numwidth+1] ? min_v : max_v;
        end else begin
            sum = wide[numwidth:0];
        end
    end
endmodule

// File: rtl/synaptic_processing_unit3.sv
// Synaptic processing unit: pops a source tag from the spike FIFO, then for
// every destination neuron reads weight and pending current, adds them with
// saturation and writes the result back. Zero weights can optionally be
// skipped, and a queued spike starts straight after the previous one ends.
module synaptic_processing_unit3
    import spu_pkg::*;
#(
    parameter int numneurons = 2,
    parameter int numwidth   = 16,
    parameter int tagbits    = 1,
    parameter int skip_zero  = 0
) (
    input  logic clk,
    input  logic asyn_reset,
    synaptic_processing_unit3_if.master bus
);
    localparam logic [tagbits-1:0] last_tag = tagbits'(numneurons - 1);

    state_t                   state_q, state_d;
    logic [tagbits-1:0]       src_tag_q, src_tag_d;
    logic [tagbits-1:0]       dst_tag_q, dst_tag_d;
    logic signed [numwidth:0] sum_q, sum_d;
    logic signed [numwidth:0] sat_sum;
    logic                     is_last;
    logic                     skip_now;

    sat_adder #(.numwidth(numwidth)) u_sat_adder (
        .a   (bus.weight_in),
        .b   (bus.i_next_in),
        .sum (sat_sum)
    );

    assign is_last  = (dst_tag_q == last_tag);
    assign skip_now = (skip_zero != 0) && (bus.weight_in == '0);

    // State and datapath registers; reset abandons any spike in flight.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q   <= S_IDLE;
            src_tag_q <= '0;
            dst_tag_q <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_tag_q <= src_tag_d;
            dst_tag_q <= dst_tag_d;
            sum_q     <= sum_d;
        end
    end

    // Next state and next datapath values; termination compares against the
    // last destination index so non-power-of-two neuron counts stop cleanly.
    always_comb begin
        state_d   = state_q;
        src_tag_d = src_tag_q;
        dst_tag_d = dst_tag_q;
        sum_d     = sum_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    state_d = S_DEQ;
                end
            end
            S_DEQ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                src_tag_d = bus.src_tag_in;
                dst_tag_d = '0;
                state_d   = S_READ;
            end
            S_READ: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d = sat_sum;
                if (skip_now) begin
                    if (is_last) begin
                        state_d = bus.fifo_empty ? S_IDLE : S_DEQ;
                    end else begin
                        dst_tag_d = dst_tag_q + tagbits'(1);
                        state_d   = S_READ;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (is_last) begin
                    state_d = bus.fifo_empty ? S_IDLE : S_DEQ;
                end else begin
                    dst_tag_d = dst_tag_q + tagbits'(1);
                    state_d   = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control strobes decoded from the registered state; data from registers.
    always_comb begin
        bus.req_deq          = (state_q == S_DEQ);
        bus.req_read         = (state_q == S_READ);
        bus.req_write_i_next = (state_q == S_WRITE);
        bus.busy             = (state_q != S_IDLE);
        bus.spike_done       = ((state_q == S_WRITE) && is_last) ||
                               ((state_q == S_ACC) && skip_now && is_last);
        bus.i_next_out       = sum_q;
        bus.src_tag_out      = src_tag_q;
        bus.dst_tag_out      = dst_tag_q;
    end
endmodule

// File: tb/tb_synaptic_processing_unit3.sv
// Scoreboard bench for synaptic_processing_unit3 with three destinations,
// 2-bit tags, 9-bit data and zero-weight skipping enabled.
module tb_synaptic_processing_unit3;
    localparam int NN   = 3;
    localparam int NW   = 8;
    localparam int TBW  = 2;
    localparam int SKIP = 1;
    localparam int DW   = NW + 1;
    localparam int NTAG = 1 << TBW;

    typedef struct {
        int src;
        int dst;
        int val;
    } wr_t;

    typedef struct {
        int src;
        int cycles;
    } done_t;

    logic clk = 1'b0;
    logic asyn_reset;

    int wmem [NTAG][NN];
    int imem [NN];
    int model_i [NN];

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    fifo_q[$];
    int    pend_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synaptic_processing_unit3_if #(.numwidth(NW), .tagbits(TBW)) bus ();

    synaptic_processing_unit3 #(
        .numneurons (NN),
        .numwidth   (NW),
        .tagbits    (TBW),
        .skip_zero  (SKIP)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .bus        (bus)
    );

    // Saturating reference add on plain integers.
    function automatic int sat_ref(input int x);
        int hi;
        int lo;
        hi = (1 << NW) - 1;
        lo = -(1 << NW);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Random weight biased toward zeros and the extremes.
    function automatic int rand_weight();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 2) return 0;
        if (r == 3) return (1 << NW) - 1;
        if (r == 4) return -(1 << NW);
        return int'($urandom_range(0, (1 << DW) - 1)) - (1 << NW);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue a spike; when tracked, the whole spike's effect is predicted now.
    task automatic applyStimulus(input int tag, input bit track);
        int cycles;
        int v;
        cycles = 2;
        if (track) begin
            for (int d = 0; d < NN; d++) begin
                if (SKIP != 0 && wmem[tag][d] == 0) begin
                    cycles += 2;
                end else begin
                    v = sat_ref(wmem[tag][d] + model_i[d]);
                    model_i[d] = v;
                    exp_wr.push_back('{tag, d, v});
                    cycles += 3;
                end
            end
            exp_done.push_back('{tag, cycles});
        end
        @(posedge clk);
        #2;
        pend_q.push_back(tag);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (n < 3000 && (exp_wr.size() != 0 || exp_done.size() != 0 ||
               fifo_q.size() != 0 || pend_q.size() != 0 || bus.busy)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
        end
    endtask

    // FIFO and memory model on the slave side of the bus.
    initial begin
        bus.fifo_empty = 1'b1;
        bus.src_tag_in = '0;
        bus.weight_in  = '0;
        bus.i_next_in  = '0;
        forever begin
            @(negedge clk);
            if (bus.req_read && int'(bus.dst_tag_out) < NN) begin
                bus.weight_in = DW'(wmem[bus.src_tag_out][bus.dst_tag_out]);
                bus.i_next_in = DW'(imem[bus.dst_tag_out]);
            end
            if (bus.req_write_i_next && int'(bus.dst_tag_out) < NN) begin
                imem[bus.dst_tag_out] = int'(bus.i_next_out);
            end
            if (bus.req_deq && fifo_q.size() > 0) begin
                bus.src_tag_in = TBW'(fifo_q.pop_front());
            end
            while (pend_q.size() > 0) begin
                fifo_q.push_back(pend_q.pop_front());
            end
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: compares every write and spike completion with the scoreboard.
    initial begin
        int  cycle;
        int  deq_cycle;
        bit  prev_done;
        bit  prev_empty;
        wr_t   w;
        done_t d;
        cycle = 0;
        deq_cycle = 0;
        prev_done = 1'b0;
        prev_empty = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            if (asyn_reset) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    checkOutput("deq_after_done", int'(bus.req_deq), prev_empty ? 0 : 1);
                    checkOutput("busy_after_done", int'(bus.busy), prev_empty ? 0 : 1);
                end
                prev_done  = bus.spike_done;
                prev_empty = bus.fifo_empty;
                if (bus.req_deq) deq_cycle = cycle;
                if (bus.req_read) begin
                    checkOutput("read_dst_range", int'(int'(bus.dst_tag_out) < NN), 1);
                end
                if (bus.req_write_i_next) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: got dst %0d val %0d, expected no write",
                                 bus.dst_tag_out, bus.i_next_out);
                    end else begin
                        w = exp_wr.pop_front();
                        checkOutput("write_src", int'(bus.src_tag_out), w.src);
                        checkOutput("write_dst", int'(bus.dst_tag_out), w.dst);
                        checkOutput("write_val", int'(bus.i_next_out), w.val);
                    end
                end
                if (bus.spike_done) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got spike_done for src %0d, expected none",
                                 bus.src_tag_out);
                    end else begin
                        d = exp_done.pop_front();
                        checkOutput("done_src", int'(bus.src_tag_out), d.src);
                        checkOutput("done_dst", int'(bus.dst_tag_out), NN - 1);
                        checkOutput("spike_cycles", cycle - deq_cycle + 1, d.cycles);
                    end
                end
            end
        end
    end

    // Main sequence: reset, directed spikes, random spikes, mid-spike reset.
    initial begin
        int found;
        asyn_reset = 1'b1;
        #1;
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_req_deq", int'(bus.req_deq), 0);
        checkOutput("rst_req_read", int'(bus.req_read), 0);
        checkOutput("rst_req_write", int'(bus.req_write_i_next), 0);
        checkOutput("rst_spike_done", int'(bus.spike_done), 0);
        checkOutput("rst_i_next_out", int'(bus.i_next_out), 0);
        checkOutput("rst_src_tag", int'(bus.src_tag_out), 0);
        checkOutput("rst_dst_tag", int'(bus.dst_tag_out), 0);

        for (int t = 0; t < NTAG; t++)
            for (int d = 0; d < NN; d++)
                wmem[t][d] = 0;
        wmem[0][0] = 0;    wmem[0][1] = 7;   wmem[0][2] = 0;
        wmem[1][0] = 255;  wmem[1][1] = 5;   wmem[1][2] = -256;
        imem[0] = 1;       imem[1] = 4;      imem[2] = -1;
        for (int d = 0; d < NN; d++) model_i[d] = imem[d];

        repeat (3) @(negedge clk);
        asyn_reset = 1'b0;

        $display("[TB] directed: skipped zeros and saturation");
        applyStimulus(0, 1'b1);
        waitIdle();
        applyStimulus(1, 1'b1);
        waitIdle();

        $display("[TB] directed: back-to-back spikes");
        applyStimulus(0, 1'b1);
        applyStimulus(1, 1'b1);
        waitIdle();

        $display("[TB] random spikes");
        for (int t = 0; t < NTAG; t++)
            for (int d = 0; d < NN; d++)
                wmem[t][d] = rand_weight();
        for (int k = 0; k < 40; k++) begin
            applyStimulus(int'($urandom_range(0, NTAG - 1)), 1'b1);
            repeat (int'($urandom_range(0, 12))) @(posedge clk);
        end
        waitIdle();

        $display("[TB] reset during first write");
        wmem[2][0] = 9;
        applyStimulus(2, 1'b0);
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            @(posedge clk);
            #1;
            if (bus.req_write_i_next) found = 1;
        end
        checkOutput("reached_write", found, 1);
        asyn_reset = 1'b1;
        #1;
        checkOutput("arst_req_write", int'(bus.req_write_i_next), 0);
        checkOutput("arst_busy", int'(bus.busy), 0);
        checkOutput("arst_i_next_out", int'(bus.i_next_out), 0);
        checkOutput("arst_src_tag", int'(bus.src_tag_out), 0);
        repeat (2) @(negedge clk);
        asyn_reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", int'(bus.busy), 0);
        checkOutput("post_reset_mem", imem[0], model_i[0]);

        applyStimulus(1, 1'b1);
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
